// File: rtl/clock_pkg.sv
// Shared constants, types and helpers for the Nixie clock time keeper.
package clock_pkg;

   localparam logic [5:0] MAX_SEC  = 6'd59;
   localparam logic [5:0] MAX_MIN  = 6'd59;
   localparam logic [4:0] MAX_HOUR = 5'd23;

   localparam logic [2:0] CURSOR_SEC  = 3'b001;
   localparam logic [2:0] CURSOR_MIN  = 3'b010;
   localparam logic [2:0] CURSOR_HOUR = 3'b100;

   typedef enum logic {ALM_IDLE, ALM_RINGING} alarm_state_t;

   typedef struct packed {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
   } tod_t;

   function automatic logic [4:0] hour_to_12h(input logic [4:0] h);
      if (h == 5'd0)       return 5'd12;
      else if (h > 5'd12)  return h - 5'd12;
      else                 return h;
   endfunction

   // Single-field step with wrap at both ends; never carries.
   function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max,
                                            input logic inc);
      if (inc) return (v == max)  ? 6'd0 : v + 6'd1;
      else     return (v == 6'd0) ? max  : v - 6'd1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles.
module tick_prescaler #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

   logic [W-1:0] cnt;

   // A restart pulls the count back to 0, so no rollover can happen that cycle.
   assign tick = en && !restart && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt <= '0;
      else if (restart) cnt <= '0;
      else if (en)      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/clock_time_keeper.sv
// Time-of-day keeper: H:M:S counter with edits, bulk load, daily alarm and 12/24 h output.
module clock_time_keeper
   import clock_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int ALARM_SECS = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode_24h,
   input  logic       run_en,
   input  logic [2:0] cursor,
   input  logic       up,
   input  logic       down,
   input  logic       clear,
   input  logic       load_valid,
   input  logic [4:0] load_h,
   input  logic [5:0] load_m,
   input  logic [5:0] load_s,
   input  logic       alarm_load,
   input  logic [4:0] alarm_h_in,
   input  logic [5:0] alarm_m_in,
   input  logic       alarm_en,
   input  logic       alarm_ack,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic       pm,
   output logic       sec_tick,
   output logic       alarm_active
);

   localparam logic [7:0] ALARM_CNT = 8'(ALARM_SECS);

   tod_t         t, t_n;
   logic [4:0]   alarm_h;
   logic [5:0]   alarm_m;
   logic [7:0]   cd, cd_n;
   alarm_state_t state, state_n;
   logic         tick, load_ok, one_hot, edit, restart, advance, match;

   assign load_ok = load_valid && (load_h <= MAX_HOUR) && (load_m <= MAX_MIN) && (load_s <= MAX_SEC);
   assign one_hot = (cursor == CURSOR_SEC) || (cursor == CURSOR_MIN) || (cursor == CURSOR_HOUR);
   assign edit    = (up ^ down) && one_hot;
   assign restart = clear || load_ok;

   tick_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (
      .clk(clk), .rst_n(rst_n), .en(run_en), .restart(restart), .tick(tick)
   );

   always_comb begin
      t_n     = t;
      advance = 1'b0;
      if (clear) begin
         t_n = '0;
      end else if (load_ok) begin
         t_n = '{h: load_h, m: load_m, s: load_s};
      end else if (edit) begin
         unique case (cursor)
            CURSOR_SEC:  t_n.s = wrap_step(t.s, MAX_SEC, up);
            CURSOR_MIN:  t_n.m = wrap_step(t.m, MAX_MIN, up);
            default:     t_n.h = 5'(wrap_step({1'b0, t.h}, {1'b0, MAX_HOUR}, up));
         endcase
      end else if (tick) begin
         advance = 1'b1;
         t_n.s   = wrap_step(t.s, MAX_SEC, 1'b1);
         if (t.s == MAX_SEC) begin
            t_n.m = wrap_step(t.m, MAX_MIN, 1'b1);
            if (t.m == MAX_MIN) t_n.h = (t.h == MAX_HOUR) ? 5'd0 : t.h + 5'd1;
         end
      end
   end

   // Only a natural advance can ring the alarm; edits landing on the alarm time stay silent.
   assign match = alarm_en && advance && (t_n == {alarm_h, alarm_m, 6'd0});

   always_comb begin
      state_n = state;
      cd_n    = cd;
      unique case (state)
         ALM_IDLE: begin
            if (match) begin
               state_n = ALM_RINGING;
               cd_n    = ALARM_CNT;
            end
         end
         ALM_RINGING: begin
            if (match) begin
               cd_n = ALARM_CNT;
            end else if (alarm_ack || !alarm_en) begin
               state_n = ALM_IDLE;
               cd_n    = 8'd0;
            end else if (tick) begin
               if (cd <= 8'd1) begin
                  state_n = ALM_IDLE;
                  cd_n    = 8'd0;
               end else begin
                  cd_n = cd - 8'd1;
               end
            end
         end
         default: state_n = ALM_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t        <= '0;
         alarm_h  <= '0;
         alarm_m  <= '0;
         cd       <= '0;
         state    <= ALM_IDLE;
         sec_tick <= 1'b0;
      end else begin
         t        <= t_n;
         cd       <= cd_n;
         state    <= state_n;
         sec_tick <= tick;
         if (alarm_load && (alarm_h_in <= MAX_HOUR) && (alarm_m_in <= MAX_MIN)) begin
            alarm_h <= alarm_h_in;
            alarm_m <= alarm_m_in;
         end
      end
   end

   assign hour         = mode_24h ? t.h : hour_to_12h(t.h);
   assign minute       = t.m;
   assign second       = t.s;
   assign pm           = (t.h >= 5'd12);
   assign alarm_active = (state == ALM_RINGING);

endmodule
